// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song table sequencer driving pitch codes from a ROM on beat pulses
module note_sequencer #(
   parameter int ADDR_BITS  = 8,
   parameter int PITCH_BITS = 6,
   parameter int DUR_BITS   = 4
) (
   input  logic                           i_clk,
   input  logic                           i_clear,
   input  logic                           i_start,
   input  logic                           i_stop,
   input  logic                           i_pause,
   input  logic                           i_loop,
   input  logic                           i_beat,
   output logic [ADDR_BITS-1:0]           o_rom_addr,
   input  logic [PITCH_BITS+DUR_BITS-1:0] i_rom_data,
   output logic [PITCH_BITS-1:0]          o_note,
   output logic                           o_note_valid,
   output logic                           o_note_change,
   output logic                           o_playing,
   output logic                           o_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_PLAY   = 3'd3,
      S_PAUSED = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t                r_state;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [PITCH_BITS-1:0] r_note;
   logic [DUR_BITS-1:0]   r_remain;
   logic                  r_note_valid;
   logic                  r_note_change;
   logic                  r_playing;
   logic                  r_done;

   logic [PITCH_BITS-1:0] w_pitch;
   logic [DUR_BITS-1:0]   w_dur;
   logic                  w_last_addr;

   assign w_pitch     = i_rom_data[PITCH_BITS+DUR_BITS-1:DUR_BITS];
   assign w_dur       = i_rom_data[DUR_BITS-1:0];
   // The top table address doubles as an end marker so the address never wraps silently.
   assign w_last_addr = (r_addr == {ADDR_BITS{1'b1}});

   // Song state machine; every output is a register updated alongside the state.
   always_ff @(posedge i_clk or posedge i_clear) begin
      if (i_clear) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_note        <= '0;
         r_remain      <= '0;
         r_note_valid  <= 1'b0;
         r_note_change <= 1'b0;
         r_playing     <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_note_change <= 1'b0;
         r_done        <= 1'b0;
         if (i_stop) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_note       <= '0;
            r_remain     <= '0;
            r_note_valid <= 1'b0;
            r_playing    <= 1'b0;
         end else if (i_start) begin
            // Restart discards whatever note was sounding.
            r_state      <= S_FETCH;
            r_addr       <= '0;
            r_note       <= '0;
            r_remain     <= '0;
            r_note_valid <= 1'b0;
            r_playing    <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               S_FETCH: begin
                  r_state <= S_LOAD;
               end
               S_LOAD: begin
                  if (w_dur == '0) begin
                     if (i_loop) begin
                        r_addr  <= '0;
                        r_state <= S_FETCH;
                     end else begin
                        r_state      <= S_FINISH;
                        r_done       <= 1'b1;
                        r_note       <= '0;
                        r_note_valid <= 1'b0;
                        r_playing    <= 1'b0;
                     end
                  end else begin
                     r_note        <= w_pitch;
                     r_remain      <= w_dur;
                     r_note_change <= 1'b1;
                     r_note_valid  <= (w_pitch != '0);
                     r_state       <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (i_pause) begin
                     r_state      <= S_PAUSED;
                     r_note_valid <= 1'b0;
                  end else if (i_beat) begin
                     if (r_remain > DUR_BITS'(1)) begin
                        r_remain <= r_remain - DUR_BITS'(1);
                     end else if (w_last_addr && !i_loop) begin
                        r_state      <= S_FINISH;
                        r_done       <= 1'b1;
                        r_note       <= '0;
                        r_note_valid <= 1'b0;
                        r_playing    <= 1'b0;
                     end else begin
                        r_addr       <= w_last_addr ? '0 : r_addr + ADDR_BITS'(1);
                        r_note_valid <= 1'b0;
                        r_state      <= S_FETCH;
                     end
                  end
               end
               S_PAUSED: begin
                  if (!i_pause) begin
                     r_state      <= S_PLAY;
                     r_note_valid <= (r_note != '0);
                  end
               end
               S_FINISH: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_rom_addr    = r_addr;
   assign o_note        = r_note;
   assign o_note_valid  = r_note_valid;
   assign o_note_change = r_note_change;
   assign o_playing     = r_playing;
   assign o_done        = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;

   logic       clk = 1'b0;
   logic       clear;
   logic       start;
   logic       stop;
   logic       pause;
   logic       loop;
   logic       beat;
   logic [1:0] rom_addr;
   logic [9:0] rom_data;
   logic [5:0] note;
   logic       note_valid;
   logic       note_change;
   logic       playing;
   logic       done;

   always #5 clk = ~clk;

   note_sequencer #(.ADDR_BITS(2), .PITCH_BITS(6), .DUR_BITS(4)) dut (
      .i_clk(clk), .i_clear(clear), .i_start(start), .i_stop(stop),
      .i_pause(pause), .i_loop(loop), .i_beat(beat),
      .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .o_note(note), .o_note_valid(note_valid), .o_note_change(note_change),
      .o_playing(playing), .o_done(done)
   );

   // synchronous ROM model, one clock read latency
   logic [9:0] rom [0:3];
   always @(posedge clk) rom_data <= rom[rom_addr];

   typedef struct {
      bit is_done;
      int pitch;
      bit nv;
      int addr;
      int beats;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   n_events = 0;
   int   beat_cnt = 0;
   bit   beat_en = 0;
   int   bcnt = 0;

   task automatic chk(input string name, input int act, input int expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic push(input bit d, input int p, input bit nv, input int a, input int b);
      exp_t e;
      e.is_done = d; e.pitch = p; e.nv = nv; e.addr = a; e.beats = b;
      exp_q.push_back(e);
   endtask

   // beat generator: one-cycle pulse every 20 clocks while enabled
   initial begin
      beat = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (beat_en) begin
            if (bcnt == 19) begin beat = 1'b1; bcnt = 0; end
            else begin beat = 1'b0; bcnt++; end
         end else begin
            beat = 1'b0;
            bcnt = 0;
         end
      end
   end

   // monitor: pops an expectation for every note_change / done pulse
   always @(negedge clk) begin
      if (!clear) begin
         if (start) beat_cnt = 0;
         if (note_change || done) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_event: note_change=%0b done=%0b note=%0d at %0t",
                        note_change, done, note, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("event_is_done", int'(done), int'(e.is_done));
               if (!e.is_done) begin
                  chk("event_note", int'(note), e.pitch);
                  chk("event_note_valid", int'(note_valid), int'(e.nv));
               end
               chk("event_rom_addr", int'(rom_addr), e.addr);
               chk("event_beats_before", beat_cnt, e.beats);
            end
            beat_cnt = 0;
            n_events++;
         end
         if (beat && !pause && playing) beat_cnt++;
      end
   end

   task automatic wait_events(input int target, input int limit);
      int k;
      k = 0;
      while (n_events < target && k < limit) begin
         @(posedge clk);
         k++;
      end
      if (n_events < target) begin
         tests++;
         fails++;
         $display("FAIL event_timeout: got %0d events expected %0d", n_events, target);
      end
   endtask

   task automatic wait_beat();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!beat && k < 100);
      if (!beat) begin
         tests++;
         fails++;
         $display("FAIL beat_timeout: beat absent for %0d cycles", k);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      beat_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk({tag, "_rom_addr"}, int'(rom_addr), 0);
      chk({tag, "_note"}, int'(note), 0);
      chk({tag, "_note_valid"}, int'(note_valid), 0);
      chk({tag, "_note_change"}, int'(note_change), 0);
      chk({tag, "_playing"}, int'(playing), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      int ev;
      clear = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
      for (int i = 0; i < 4; i++) rom[i] = '0;
      repeat (3) @(posedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      clear = 1'b0;

      // 1: two notes then end marker, no loop
      rom[0] = {6'd5, 4'd2}; rom[1] = {6'd9, 4'd1}; rom[2] = 10'd0; rom[3] = 10'd0;
      push(0, 5, 1, 0, 0); push(0, 9, 1, 1, 2); push(1, 0, 0, 2, 1);
      ev = n_events;
      pulse_start();
      wait_events(ev + 3, 400);
      @(posedge clk);
      @(negedge clk);
      chk("t1_playing_after", int'(playing), 0);
      chk("t1_note_after", int'(note), 0);
      beat_en = 1'b0;

      // 2: same song looping; rom_addr returns to 0, no done
      loop = 1'b1;
      push(0, 5, 1, 0, 0); push(0, 9, 1, 1, 2); push(0, 5, 1, 0, 1); push(0, 9, 1, 1, 2);
      ev = n_events;
      pulse_start();
      wait_events(ev + 4, 600);
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      loop = 1'b0;
      beat_en = 1'b0;
      check_idle("t2_stop");

      // 3: rest entry is announced but silent for 3 beats
      rom[0] = {6'd0, 4'd3}; rom[1] = {6'd5, 4'd1}; rom[2] = 10'd0;
      push(0, 0, 0, 0, 0); push(0, 5, 1, 1, 3); push(1, 0, 0, 2, 1);
      ev = n_events;
      pulse_start();
      wait_events(ev + 3, 600);
      beat_en = 1'b0;

      // 4: pause for 3 beats after the first beat of a 4-beat note
      rom[0] = {6'd5, 4'd4}; rom[1] = 10'd0;
      push(0, 5, 1, 0, 0); push(1, 0, 0, 1, 4);
      ev = n_events;
      pulse_start();
      wait_events(ev + 1, 100);
      wait_beat();
      repeat (10) @(posedge clk);
      #1 pause = 1'b1;
      for (int i = 0; i < 3; i++) wait_beat();
      chk("t4_note_valid_paused", int'(note_valid), 0);
      chk("t4_playing_paused", int'(playing), 1);
      chk("t4_note_held", int'(note), 5);
      repeat (10) @(posedge clk);
      #1 pause = 1'b0;
      wait_events(ev + 2, 400);
      beat_en = 1'b0;

      // 5: table full of notes; last address ends the song without wrapping
      rom[0] = {6'd1, 4'd1}; rom[1] = {6'd2, 4'd1}; rom[2] = {6'd3, 4'd1}; rom[3] = {6'd4, 4'd1};
      push(0, 1, 1, 0, 0); push(0, 2, 1, 1, 1); push(0, 3, 1, 2, 1); push(0, 4, 1, 3, 1);
      push(1, 0, 0, 3, 1);
      ev = n_events;
      pulse_start();
      wait_events(ev + 5, 600);
      @(posedge clk);
      @(negedge clk);
      chk("t5_rom_addr_no_wrap", int'(rom_addr), 3);
      chk("t5_playing_after", int'(playing), 0);
      beat_en = 1'b0;

      // 6a: stop and start together mid-note -> idle
      rom[0] = {6'd5, 4'd4}; rom[1] = 10'd0;
      push(0, 5, 1, 0, 0);
      ev = n_events;
      pulse_start();
      wait_events(ev + 1, 100);
      wait_beat();
      @(posedge clk); #1;
      stop = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0; start = 1'b0;
      beat_en = 1'b0;
      check_idle("t6_stop_start");
      repeat (5) @(posedge clk);
      chk("t6_stays_idle", int'(playing), 0);

      // 6b: clear mid-note -> immediate reset values, no done pulse
      push(0, 5, 1, 0, 0);
      ev = n_events;
      pulse_start();
      wait_events(ev + 1, 100);
      wait_beat();
      #2 clear = 1'b1;
      #1;
      chk("t6_clear_playing", int'(playing), 0);
      chk("t6_clear_note", int'(note), 0);
      chk("t6_clear_note_valid", int'(note_valid), 0);
      chk("t6_clear_done", int'(done), 0);
      @(posedge clk); #1;
      clear = 1'b0;
      repeat (80) @(posedge clk);
      beat_en = 1'b0;
      chk("t6_no_event_after_clear", n_events, ev + 1);

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
